servo_pwm_array: RTL and testbench

- Parametrised N-channel hobby-servo PWM engine. It is the successor of the fixed two-axis H/V servo drivers in the solar-panel tracker.
- Each channel holds a commanded target pulse width, clamped to limits, and slews its live pulse width toward that target by a bounded step once per frame.
- The tracking FSM or the button logic issues target commands over a valid/ready port. SERVO outputs drive the pins directly.

---
 rtl/servo_pkg.sv | 33 +++
 rtl/servo_channel.sv | 96 +++++++++
 rtl/servo_pwm_array.sv | 171 +++++++++++++++++
 tb/tb_servo_pwm_array.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared definitions for the servo PWM array: command opcodes, command FSM
// states and small constant helpers used to size ports and derive the
// centre pulse width.
package servo_pkg;

    typedef enum logic [1:0] {
        OP_SET    = 2'b00,
        OP_INC    = 2'b01,
        OP_DEC    = 2'b10,
        OP_CENTER = 2'b11
    } cmd_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_APPLY = 1'b1
    } cmd_state_e;

    // Ceiling log2 for elaboration-time sizing.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Neutral servo position, midway between the pulse limits.
    function automatic int center_of(input int min_cyc, input int max_cyc);
        return (min_cyc + max_cyc) / 2;
    endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo channel: commanded target, live pulse width slewed once per
// frame, registered PWM output, at-target and sticky clamp flags.
// OFFSET_CYC shifts this channel's pulse start within the frame; the top
// level sets it non-zero only when SERVO_STAGGER_EN is defined.
module servo_channel
    import servo_pkg::*;
#(
    parameter int W          = 32,
    parameter int PERIOD_CYC = 2000000,
    parameter int MIN_CYC    = 50000,
    parameter int MAX_CYC    = 250000,
    parameter int SLEW_CYC   = 1000,
    parameter int OFFSET_CYC = 0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic [W-1:0] i_frame_cnt,
    input  logic         i_boundary,
    input  logic         i_wr,
    input  logic [W-1:0] i_wr_target,
    input  logic         i_wr_min,
    input  logic         i_wr_max,
    output logic         o_servo,
    output logic [W-1:0] o_live,
    output logic [W-1:0] o_target,
    output logic         o_at_target,
    output logic         o_lim_min,
    output logic         o_lim_max
);

    localparam logic [W-1:0] CENTER = W'(center_of(MIN_CYC, MAX_CYC));
    localparam logic [W-1:0] SLEW   = W'(SLEW_CYC);
    localparam logic [W-1:0] PERIOD = W'(PERIOD_CYC);
    localparam logic [W:0]   OFFSET = (W+1)'(OFFSET_CYC);

    logic [W-1:0] r_target;
    logic [W-1:0] r_live;
    logic         r_servo;
    logic         r_at;
    logic         r_min;
    logic         r_max;

    logic [W-1:0] w_diff;
    logic [W-1:0] w_step;
    logic [W-1:0] w_live_nxt;
    logic [W-1:0] w_target_nxt;
    logic [W:0]   w_phase_raw;
    logic [W-1:0] w_phase;

    // Next live width: on the frame boundary move toward the current (pre-write) target by at most SLEW.
    always_comb begin
        w_diff       = (r_target >= r_live) ? (r_target - r_live) : (r_live - r_target);
        w_step       = (w_diff > SLEW) ? SLEW : w_diff;
        w_live_nxt   = r_live;
        if (i_boundary) begin
            w_live_nxt = (r_target >= r_live) ? (r_live + w_step) : (r_live - w_step);
        end
        w_target_nxt = i_wr ? i_wr_target : r_target;
    end

    // Frame position relative to this channel's start offset, wrapped by compare-and-add.
    always_comb begin
        w_phase_raw = {1'b0, i_frame_cnt} - OFFSET;
        w_phase     = w_phase_raw[W] ? (w_phase_raw[W-1:0] + PERIOD) : w_phase_raw[W-1:0];
    end

    // Channel state: target/live registers, PWM compare, at-target and sticky clamp flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_target <= CENTER;
            r_live   <= CENTER;
            r_servo  <= 1'b0;
            r_at     <= 1'b1;
            r_min    <= 1'b0;
            r_max    <= 1'b0;
        end else begin
            r_target <= w_target_nxt;
            r_live   <= w_live_nxt;
            r_servo  <= i_en && (w_phase < r_live);
            r_at     <= (w_live_nxt == w_target_nxt);
            if (i_wr) begin
                r_min <= i_wr_min;
                r_max <= i_wr_max;
            end
        end
    end

    assign o_servo     = r_servo;
    assign o_live      = r_live;
    assign o_target    = r_target;
    assign o_at_target = r_at;
    assign o_lim_min   = r_min;
    assign o_lim_max   = r_max;

endmodule

// File: rtl/servo_pwm_array.sv
// N-channel hobby-servo PWM engine. Owns the frame counter, the two-state
// command FSM and target clamping; each channel is a servo_channel.
// Define SERVO_STAGGER_EN to offset channel i's pulse by i*(PERIOD_CYC/NCH).
module servo_pwm_array
    import servo_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int W          = 32,
    parameter int PERIOD_CYC = 2000000,
    parameter int MIN_CYC    = 50000,
    parameter int MAX_CYC    = 250000,
    parameter int SLEW_CYC   = 1000,
    localparam int CHW       = (NCH > 1) ? clog2(NCH) : 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [NCH-1:0]   EN,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [CHW-1:0]   CMD_CH,
    input  logic [1:0]       CMD_OP,
    input  logic [W-1:0]     CMD_VAL,
    output logic [NCH-1:0]   SERVO,
    output logic [NCH*W-1:0] POS,
    output logic [NCH-1:0]   AT_TARGET,
    output logic [NCH-1:0]   LIMIT_MIN,
    output logic [NCH-1:0]   LIMIT_MAX,
    output logic             FRAME_TICK
);

    localparam int                CENTER = center_of(MIN_CYC, MAX_CYC);
    localparam logic [W-1:0]      LAST   = W'(PERIOD_CYC - 1);
    localparam logic signed [W+1:0] MIN_S = (W+2)'(MIN_CYC);
    localparam logic signed [W+1:0] MAX_S = (W+2)'(MAX_CYC);

    logic [W-1:0]        r_frame_cnt;
    logic                r_frame_tick;
    logic                w_boundary;

    cmd_state_e          r_state;
    cmd_state_e          w_state_nxt;
    logic                w_accept;
    logic                w_apply;
    logic [CHW-1:0]      r_cmd_ch;
    cmd_op_e             r_cmd_op;
    logic [W-1:0]        r_cmd_val;

    logic [W-1:0]        w_target [NCH];
    logic [W-1:0]        w_live   [NCH];
    logic [W-1:0]        w_cur_target;
    logic signed [W+1:0] w_t;
    logic [W-1:0]        w_new_target;
    logic                w_clamp_min;
    logic                w_clamp_max;
    logic [NCH-1:0]      w_wr;

    // Limit an unbounded signed target to the legal pulse window.
    function automatic logic [W-1:0] clamp_target(input logic signed [W+1:0] t);
        if (t < MIN_S)      return W'(MIN_CYC);
        else if (t > MAX_S) return W'(MAX_CYC);
        else                return t[W-1:0];
    endfunction

    assign w_boundary = (r_frame_cnt == LAST);

    // Free-running frame counter and one-cycle tick following the last count.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_frame_cnt  <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_cnt  <= w_boundary ? '0 : (r_frame_cnt + W'(1));
            r_frame_tick <= w_boundary;
        end
    end

    // Command FSM state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Command FSM: accept in IDLE, apply the clamped target in the following cycle.
    always_comb begin
        w_state_nxt = r_state;
        CMD_READY   = 1'b0;
        w_accept    = 1'b0;
        w_apply     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                CMD_READY = 1'b1;
                if (CMD_VALID) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_APPLY;
                end
            end
            ST_APPLY: begin
                w_apply     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Capture the accepted command for use in APPLY.
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_cmd_ch  <= CMD_CH;
            r_cmd_op  <= cmd_op_e'(CMD_OP);
            r_cmd_val <= CMD_VAL;
        end
    end

    // New target in W+2 signed bits so INC cannot wrap and DEC can go negative; out-of-range channels get no write.
    always_comb begin
        w_cur_target = '0;
        w_wr         = '0;
        w_t          = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_cmd_ch == CHW'(i)) begin
                w_cur_target = w_target[i];
                w_wr[i]      = w_apply;
            end
        end
        case (r_cmd_op)
            OP_SET:  w_t = $signed({2'b00, r_cmd_val});
            OP_INC:  w_t = $signed({2'b00, w_cur_target}) + $signed({2'b00, r_cmd_val});
            OP_DEC:  w_t = $signed({2'b00, w_cur_target}) - $signed({2'b00, r_cmd_val});
            default: w_t = (W+2)'(CENTER);
        endcase
        w_clamp_min  = (w_t < MIN_S);
        w_clamp_max  = (w_t > MAX_S);
        w_new_target = clamp_target(w_t);
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
`ifdef SERVO_STAGGER_EN
        localparam int OFF = i * (PERIOD_CYC / NCH);
`else
        localparam int OFF = 0;
`endif
        servo_channel #(
            .W          (W),
            .PERIOD_CYC (PERIOD_CYC),
            .MIN_CYC    (MIN_CYC),
            .MAX_CYC    (MAX_CYC),
            .SLEW_CYC   (SLEW_CYC),
            .OFFSET_CYC (OFF)
        ) u_ch (
            .i_clk       (CLK),
            .i_rst_n     (RST_N),
            .i_en        (EN[i]),
            .i_frame_cnt (r_frame_cnt),
            .i_boundary  (w_boundary),
            .i_wr        (w_wr[i]),
            .i_wr_target (w_new_target),
            .i_wr_min    (w_clamp_min),
            .i_wr_max    (w_clamp_max),
            .o_servo     (SERVO[i]),
            .o_live      (w_live[i]),
            .o_target    (w_target[i]),
            .o_at_target (AT_TARGET[i]),
            .o_lim_min   (LIMIT_MIN[i]),
            .o_lim_max   (LIMIT_MAX[i])
        );
        assign POS[i*W +: W] = w_live[i];
    end

    assign FRAME_TICK = r_frame_tick;

endmodule

// File: tb/tb_servo_pwm_array.sv
// Bench for servo_pwm_array with NCH=2, PERIOD=1000, MIN=50, MAX=250, SLEW=20.
// A behavioural model tracks targets and live widths from the command rules;
// a frame-level expectation is queued at every boundary and popped by the
// monitor on FRAME_TICK, together with per-cycle output checks.
module tb_servo_pwm_array;

    localparam int NCH = 2;
    localparam int W   = 32;
    localparam int P   = 1000;
    localparam int MN  = 50;
    localparam int MX  = 250;
    localparam int SL  = 20;
    localparam int CTR = (MN + MX) / 2;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic [NCH-1:0]   EN = 2'b11;
    logic             CMD_VALID = 1'b0;
    logic             CMD_READY;
    logic [0:0]       CMD_CH = 1'b0;
    logic [1:0]       CMD_OP = 2'b00;
    logic [W-1:0]     CMD_VAL = '0;
    logic [NCH-1:0]   SERVO;
    logic [NCH*W-1:0] POS;
    logic [NCH-1:0]   AT_TARGET;
    logic [NCH-1:0]   LIMIT_MIN;
    logic [NCH-1:0]   LIMIT_MAX;
    logic             FRAME_TICK;

    int n_checks = 0;
    int n_errors = 0;

    servo_pwm_array #(
        .NCH(NCH), .W(W), .PERIOD_CYC(P), .MIN_CYC(MN), .MAX_CYC(MX), .SLEW_CYC(SL)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_CH(CMD_CH), .CMD_OP(CMD_OP), .CMD_VAL(CMD_VAL),
        .SERVO(SERVO), .POS(POS), .AT_TARGET(AT_TARGET),
        .LIMIT_MIN(LIMIT_MIN), .LIMIT_MAX(LIMIT_MAX), .FRAME_TICK(FRAME_TICK)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        longint   live0;
        longint   live1;
        int       pwm0;
        int       pwm1;
        logic [1:0] at;
    } snap_t;

    snap_t exp_q[$];

    // Reference model state
    longint     m_tgt [NCH];
    longint     m_live[NCH];
    logic [1:0] m_lmin, m_lmax, m_fen;
    int         m_fc;
    bit         m_busy;
    int         p_ch, p_op;
    longint     p_val;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_tgt[i]  = CTR;
            m_live[i] = CTR;
        end
        m_lmin = '0; m_lmax = '0; m_fen = '0;
        m_fc = 0; m_busy = 0;
        exp_q.delete();
    endtask

    task automatic model_apply(input int ch, input int op, input longint val);
        longint t;
        case (op)
            0:       t = val;
            1:       t = m_tgt[ch] + val;
            2:       t = m_tgt[ch] - val;
            default: t = CTR;
        endcase
        if (t < MN) begin
            m_tgt[ch] = MN; m_lmin[ch] = 1'b1; m_lmax[ch] = 1'b0;
        end else if (t > MX) begin
            m_tgt[ch] = MX; m_lmin[ch] = 1'b0; m_lmax[ch] = 1'b1;
        end else begin
            m_tgt[ch] = t;  m_lmin[ch] = 1'b0; m_lmax[ch] = 1'b0;
        end
    endtask

    // Behavioural model: one update per clock edge, slew before command write.
    initial begin
        snap_t  s;
        bit     bnd;
        longint d;
        model_reset();
        forever begin
            @(posedge CLK or negedge RST_N);
            if (!RST_N) begin
                model_reset();
            end else begin
                bnd = (m_fc == P - 1);
                if (m_fc == 0) m_fen = EN;
                if (bnd) begin
                    s.pwm0 = m_fen[0] ? int'(m_live[0]) : 0;
                    s.pwm1 = m_fen[1] ? int'(m_live[1]) : 0;
                    for (int i = 0; i < NCH; i++) begin
                        d = m_tgt[i] - m_live[i];
                        if (d > SL)  d = SL;
                        if (d < -SL) d = -SL;
                        m_live[i] = m_live[i] + d;
                    end
                end
                if (m_busy) begin
                    model_apply(p_ch, p_op, p_val);
                    m_busy = 0;
                end else if (CMD_VALID) begin
                    p_ch = int'(CMD_CH); p_op = int'(CMD_OP); p_val = longint'(CMD_VAL);
                    m_busy = 1;
                end
                m_fc = (m_fc == P - 1) ? 0 : m_fc + 1;
                if (bnd) begin
                    s.live0 = m_live[0];
                    s.live1 = m_live[1];
                    s.at    = {m_live[1] == m_tgt[1], m_live[0] == m_tgt[0]};
                    exp_q.push_back(s);
                end
            end
        end
    end

    // Monitor: per-cycle outputs against the model, frame results popped on FRAME_TICK.
    initial begin
        int    cnt0, cnt1;
        bit    win;
        snap_t s;
`ifdef SERVO_STAGGER_EN
        logic  prev1;
        prev1 = 1'b0;
`endif
        cnt0 = 0; cnt1 = 0; win = 0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                win = 0; cnt0 = 0; cnt1 = 0;
`ifdef SERVO_STAGGER_EN
                prev1 = 1'b0;
`endif
            end else begin
                check("cmd_ready", CMD_READY, !m_busy);
                check("pos0", POS[W-1:0], m_live[0]);
                check("pos1", POS[2*W-1:W], m_live[1]);
                check("at_target", AT_TARGET, {m_live[1] == m_tgt[1], m_live[0] == m_tgt[0]});
                check("limit_min", LIMIT_MIN, m_lmin);
                check("limit_max", LIMIT_MAX, m_lmax);
                check("frame_tick", FRAME_TICK, exp_q.size() != 0);
`ifdef SERVO_STAGGER_EN
                if (SERVO[1] && !prev1) check("stagger_rise1", m_fc, P / 2 + 1);
                prev1 = SERVO[1];
`endif
                if (exp_q.size() != 0) begin
                    s = exp_q.pop_front();
                    if (FRAME_TICK) begin
                        check("frame_pos0", POS[W-1:0], s.live0);
                        check("frame_pos1", POS[2*W-1:W], s.live1);
                        check("frame_at", AT_TARGET, s.at);
                        if (win) begin
                            check("pwm_width0", cnt0, s.pwm0);
                            check("pwm_width1", cnt1, s.pwm1);
                        end
                    end
                end
                if (FRAME_TICK) begin
                    win  = 1;
                    cnt0 = int'(SERVO[0]);
                    cnt1 = int'(SERVO[1]);
                end else begin
                    cnt0 += int'(SERVO[0]);
                    cnt1 += int'(SERVO[1]);
                end
            end
        end
    end

    task automatic send(input int ch, input int op, input longint val);
        @(negedge CLK);
        for (int g = 0; g < 4 && m_busy; g++) @(negedge CLK);
        CMD_VALID = 1'b1;
        CMD_CH    = 1'(ch);
        CMD_OP    = 2'(op);
        CMD_VAL   = 32'(val);
        @(negedge CLK);
        CMD_VALID = 1'b0;
    endtask

    task automatic wait_fc(input int n);
        for (int g = 0; g < 2 * P && m_fc != n; g++) @(negedge CLK);
    endtask

    task automatic set_en(input logic [1:0] v);
        wait_fc(0);
        EN = v;
    endtask

    // Stimulus
    initial begin
        int acc, first, gap;
        int ch, op;
        longint val;

        RST_N = 1'b0;
        EN    = 2'b11;
        repeat (3) @(negedge CLK);
        check("rst_pos0", POS[W-1:0], CTR);
        check("rst_pos1", POS[2*W-1:W], CTR);
        check("rst_at", AT_TARGET, 2'b11);
        check("rst_servo", SERVO, 2'b00);
        check("rst_lmin", LIMIT_MIN, 2'b00);
        check("rst_lmax", LIMIT_MAX, 2'b00);
        check("rst_tick", FRAME_TICK, 0);
        check("rst_ready", CMD_READY, 1);
        RST_N = 1'b1;
        repeat (3 * P) @(negedge CLK);

        // Ramp channel 0 up to 230 in 20-cycle steps
        send(0, 0, 230);
        repeat (5 * P) @(negedge CLK);
        check("ramp_pos0", POS[W-1:0], 230);
        check("ramp_at0", AT_TARGET[0], 1);
        check("ramp_pos1", POS[2*W-1:W], CTR);

        // Upper clamp and flag clearing
        send(1, 0, 400);
        @(negedge CLK);
        check("lmax1_set", LIMIT_MAX[1], 1);
        send(1, 0, 200);
        @(negedge CLK);
        check("lmax1_clr", LIMIT_MAX[1], 0);

        // Lower clamp, DEC below zero must not wrap
        send(0, 0, 60);
        send(0, 2, 30);
        @(negedge CLK);
        check("lmin0_set", LIMIT_MIN[0], 1);
        send(0, 2, 100);
        @(negedge CLK);
        check("lmin0_nowrap", LIMIT_MIN[0], 1);
        check("lmax0_nowrap", LIMIT_MAX[0], 0);
        repeat (2 * P) @(negedge CLK);

        // Valid held for four cycles
        @(negedge CLK);
        for (int g = 0; g < 4 && m_busy; g++) @(negedge CLK);
        CMD_VALID = 1'b1; CMD_CH = 1'b1; CMD_OP = 2'b01; CMD_VAL = 32'd5;
        acc = 0; first = -1; gap = -1;
        for (int k = 0; k < 4; k++) begin
            if (CMD_READY) begin
                acc++;
                if (first < 0) first = k;
                else gap = k - first;
            end
            @(negedge CLK);
        end
        CMD_VALID = 1'b0;
        check("held_accepts", acc, 2);
        check("held_gap", gap, 2);

        // Command whose APPLY lands on the frame-boundary cycle
        repeat (2) @(negedge CLK);
        wait_fc(P - 2);
        CMD_VALID = 1'b1; CMD_CH = 1'b0; CMD_OP = 2'b00; CMD_VAL = 32'd240;
        @(negedge CLK);
        CMD_VALID = 1'b0;
        repeat (3 * P) @(negedge CLK);

        // Randomised commands and enable changes
        repeat (30) begin
            ch = int'($urandom_range(0, 1));
            op = int'($urandom_range(0, 3));
            if (op == 0) val = longint'($urandom_range(0, 400));
            else if ($urandom_range(0, 3) == 0) val = 64'h0000_0000_FFFF_FFFF;
            else val = longint'($urandom_range(0, 300));
            send(ch, op, val);
            repeat ($urandom_range(1, 500)) @(negedge CLK);
            if ($urandom_range(0, 3) == 0) set_en(2'($urandom_range(0, 3)));
        end

        // Channel 1 disabled while it keeps ramping
        set_en(2'b11);
        send(1, 0, 250);
        repeat (6 * P) @(negedge CLK);
        set_en(2'b01);
        send(1, 0, 60);
        repeat (4 * P) @(negedge CLK);

        // Asynchronous reset in the middle of the ramp
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("arst_pos0", POS[W-1:0], CTR);
        check("arst_pos1", POS[2*W-1:W], CTR);
        check("arst_at", AT_TARGET, 2'b11);
        @(negedge CLK);
        EN = 2'b11;
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (2 * P + 10) @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
